if_id_pipe: RTL and testbench
=============================

Name: if_id_pipe

Overview:
- Parametrised IF/ID pipeline register for the RV32I 5-stage pipelined CPU with hazards unit.
- Sits between fetch and decode.
- Registers PC, PC+4, instruction word and a valid bit, and drives the decoded instruction fields to the ID stage.
- Adds hazard-unit stall (hold) and flush (bubble insertion) control, replacing killed or invalid instructions with a canonical NOP.

Parameters:
- XLEN, 32, width of pc and pc_plus_4 paths.
- NOP_INSTR, 32'h0000_0013, instruction word inserted on bubble (addi x0,x0,0).
- CNT_W, 16, width of optional performance counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_id  input  1  hazard unit: hold current ID contents.
- flush_id  input  1  hazard unit: kill ID contents (insert bubble).
- valid_if  input  1  fetch stage presents a real instruction.
- pc_if  input  XLEN  fetch PC.
- pc_plus_4_if  input  XLEN  fetch PC+4.
- im_data_if  input  32  fetched instruction word.
- valid_id  output  1  ID holds a real instruction.
- pc_id  output  XLEN  registered PC.
- pc_plus_4_id  output  XLEN  registered PC+4.
- im_data_id  output  32  registered instruction (NOP_INSTR when bubble).
- opcode_id  output  7  im_data_id[6:0].
- rd_id  output  5  im_data_id[11:7].
- func_3_id  output  3  im_data_id[14:12].
- rs1_id  output  5  im_data_id[19:15].
- rs2_id  output  5  im_data_id[24:20].
- func_7_bit_6_id  output  1  im_data_id[30].
- stall_cnt_id  output  CNT_W  stall-cycle count (PERF_CNT_EN only).
- flush_cnt_id  output  CNT_W  flush count (PERF_CNT_EN only).

Behaviour:
- Register update priority on each rising clk: rst > flush_id > stall_id > load.
- rst=1:
  - valid_id=0, pc_id=0, pc_plus_4_id=0, im_data_id=NOP_INSTR.
  - Field outputs therefore read opcode 7'h13, rd 0, func_3 0, rs1 0, rs2 0, func_7_bit_6 0.
  - Counters cleared.
  - Reset asserted mid-stall or mid-flush discards all held state; the first load follows the cycle after rst deasserts.
- flush_id=1 (rst=0): bubble.
  - valid_id=0, im_data_id=NOP_INSTR, pc_id=0, pc_plus_4_id=0.
  - Flush beats stall when both are asserted (branch redirect must kill the held instruction).
- stall_id=1, flush_id=0: all registers hold their value; inputs are ignored.
  - A stall of any length N keeps outputs identical for N cycles.
  - The input presented on the cycle stall drops is the one loaded.
- Load (rst=0, flush_id=0, stall_id=0):
  - pc_id<=pc_if, pc_plus_4_id<=pc_plus_4_if.
  - If valid_if=1: im_data_id<=im_data_if, valid_id<=1.
  - If valid_if=0: im_data_id<=NOP_INSTR, valid_id<=0; pc values still captured.
- Latency: exactly one cycle from IF input to ID output. No combinational path from any input to any output.
- Field outputs are pure bit slices of the im_data_id register. No separate field registers, so fields can never disagree with im_data_id.
- pc_plus_4_if is not recomputed internally; the block passes it through unchanged (no arithmetic, no wrap handling).

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined:
  - stall_cnt_id increments by 1 on every clock with stall_id=1 and flush_id=0 and rst=0.
  - flush_cnt_id increments by 1 on every clock with flush_id=1 and rst=0.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - Both cleared by rst.
- Not defined:
  - Counter ports and logic are absent.
  - Module port list excludes stall_cnt_id and flush_cnt_id.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> valid_id=0, pc_id=0, im_data_id=32'h00000013, opcode_id=7'h13, all other fields 0.
- Load: valid_if=1, pc_if=32'h100, pc_plus_4_if=32'h104, im_data_if=32'h00A28293 -> next cycle:
  - valid_id=1, pc_id=32'h100.
  - opcode_id=7'h13, rd_id=5, func_3_id=0, rs1_id=5, rs2_id=10, func_7_bit_6_id=0.
- Stall: load 32'h40B50533, then stall_id=1 for 3 cycles while inputs change to 32'hFFFFFFFF -> outputs held:
  - im_data_id=32'h40B50533, func_7_bit_6_id=1.
  - Next unstalled load takes the new input.
- Flush over stall: stall_id=1 and flush_id=1 together with valid instruction held -> next cycle valid_id=0, im_data_id=NOP_INSTR, pc_id=0.
- Invalid fetch: valid_if=0, pc_if=32'h200, im_data_if=32'hDEADBEEF -> valid_id=0, im_data_id=32'h00000013, pc_id=32'h200.
- Counters (IF_ID_PERF_CNT_EN, CNT_W=2):
  - 5 stall cycles then 1 flush -> stall_cnt_id=3 (saturated), flush_cnt_id=1.
  - rst -> both 0.

Source files
------------

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with hazard stall/flush and NOP bubble insertion.
// Define IF_ID_PERF_CNT_EN to add saturating stall/flush cycle counters.
module if_id_pipe #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_id,
  input  logic            flush_id,
  input  logic            valid_if,
  input  logic [XLEN-1:0] pc_if,
  input  logic [XLEN-1:0] pc_plus_4_if,
  input  logic [31:0]     im_data_if,
  output logic            valid_id,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus_4_id,
  output logic [31:0]     im_data_id,
  output logic [6:0]      opcode_id,
  output logic [4:0]      rd_id,
  output logic [2:0]      func_3_id,
  output logic [4:0]      rs1_id,
  output logic [4:0]      rs2_id,
  output logic            func_7_bit_6_id
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_id,
  output logic [CNT_W-1:0] flush_cnt_id
`endif
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_id     <= 1'b0;
      pc_id        <= '0;
      pc_plus_4_id <= '0;
      im_data_id   <= NOP_INSTR;
    end else if (flush_id) begin
      valid_id     <= 1'b0;
      pc_id        <= '0;
      pc_plus_4_id <= '0;
      im_data_id   <= NOP_INSTR;
    end else if (!stall_id) begin
      valid_id     <= valid_if;
      pc_id        <= pc_if;
      pc_plus_4_id <= pc_plus_4_if;
      im_data_id   <= valid_if ? im_data_if : NOP_INSTR;
    end
  end

  // Fields are slices of the one register so they always agree with it.
  assign opcode_id       = im_data_id[6:0];
  assign rd_id           = im_data_id[11:7];
  assign func_3_id       = im_data_id[14:12];
  assign rs1_id          = im_data_id[19:15];
  assign rs2_id          = im_data_id[24:20];
  assign func_7_bit_6_id = im_data_id[30];

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_id <= '0;
      flush_cnt_id <= '0;
    end else if (flush_id) begin
      if (flush_cnt_id != '1)
        flush_cnt_id <= flush_cnt_id + CNT_W'(1);
    end else if (stall_id) begin
      if (stall_cnt_id != '1)
        stall_cnt_id <= stall_cnt_id + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe: directed plan plus random traffic.
// Expected ID state comes from a rule-level model of the pipe register.
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_PERF_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_id = 1'b0;
  logic        flush_id = 1'b0;
  logic        valid_if = 1'b0;
  logic [31:0] pc_if = '0;
  logic [31:0] pc_plus_4_if = '0;
  logic [31:0] im_data_if = '0;
  logic        valid_id;
  logic [31:0] pc_id;
  logic [31:0] pc_plus_4_id;
  logic [31:0] im_data_id;
  logic [6:0]  opcode_id;
  logic [4:0]  rd_id;
  logic [2:0]  func_3_id;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        func_7_bit_6_id;
`ifdef IF_ID_PERF_CNT_EN
  logic [CW-1:0] stall_cnt_id;
  logic [CW-1:0] flush_cnt_id;
`endif

  if_id_pipe #(
    .XLEN(32),
    .NOP_INSTR(NOP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_id(stall_id),
    .flush_id(flush_id),
    .valid_if(valid_if),
    .pc_if(pc_if),
    .pc_plus_4_if(pc_plus_4_if),
    .im_data_if(im_data_if),
    .valid_id(valid_id),
    .pc_id(pc_id),
    .pc_plus_4_id(pc_plus_4_id),
    .im_data_id(im_data_id),
    .opcode_id(opcode_id),
    .rd_id(rd_id),
    .func_3_id(func_3_id),
    .rs1_id(rs1_id),
    .rs2_id(rs2_id),
    .func_7_bit_6_id(func_7_bit_6_id)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt_id(stall_cnt_id),
    .flush_cnt_id(flush_cnt_id)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] im;
    int          sc;
    int          fc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  task automatic chk(input string name, input string tag,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s [%s] got %h expected %h", name, tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what ID must hold after the edge.
  task automatic step(input string tag, input bit r, input bit s,
                      input bit f, input bit v, input logic [31:0] pc,
                      input logic [31:0] im);
    @(negedge clk);
    rst = r;
    stall_id = s;
    flush_id = f;
    valid_if = v;
    pc_if = pc;
    pc_plus_4_if = pc + 32'd4;
    im_data_if = im;
    m.tag = tag;
    if (r) begin
      m.v = 0; m.pc = 0; m.pc4 = 0; m.im = NOP; m.sc = 0; m.fc = 0;
    end else if (f) begin
      m.v = 0; m.pc = 0; m.pc4 = 0; m.im = NOP;
      m.fc = (m.fc < CMAX) ? m.fc + 1 : CMAX;
    end else if (s) begin
      m.sc = (m.sc < CMAX) ? m.sc + 1 : CMAX;
    end else begin
      m.v = v; m.pc = pc; m.pc4 = pc + 32'd4;
      m.im = v ? im : NOP;
    end
    q.push_back(m);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid_id", e.tag, {31'd0, valid_id}, {31'd0, e.v});
        chk("pc_id", e.tag, pc_id, e.pc);
        chk("pc_plus_4_id", e.tag, pc_plus_4_id, e.pc4);
        chk("im_data_id", e.tag, im_data_id, e.im);
        chk("opcode_id", e.tag, {25'd0, opcode_id}, {25'd0, e.im[6:0]});
        chk("rd_id", e.tag, {27'd0, rd_id}, {27'd0, e.im[11:7]});
        chk("func_3_id", e.tag, {29'd0, func_3_id}, {29'd0, e.im[14:12]});
        chk("rs1_id", e.tag, {27'd0, rs1_id}, {27'd0, e.im[19:15]});
        chk("rs2_id", e.tag, {27'd0, rs2_id}, {27'd0, e.im[24:20]});
        chk("func_7_bit_6_id", e.tag, {31'd0, func_7_bit_6_id},
            {31'd0, e.im[30]});
`ifdef IF_ID_PERF_CNT_EN
        chk("stall_cnt_id", e.tag, 32'(stall_cnt_id), 32'(e.sc));
        chk("flush_cnt_id", e.tag, 32'(flush_cnt_id), 32'(e.fc));
`endif
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog timeout, got no end expected end");
      $fatal(1, "timeout");
    end
  end

  initial begin : stim
    m = '{tag: "init", v: 0, pc: 0, pc4: 0, im: NOP, sc: 0, fc: 0};
    step("reset0", 1, $urandom_range(0, 1), $urandom_range(0, 1), 1,
         $urandom, $urandom);
    step("reset1", 1, $urandom_range(0, 1), $urandom_range(0, 1), 1,
         $urandom, $urandom);
    step("load100", 0, 0, 0, 1, 32'h100, 32'h00A2_8293);
    step("load_sub", 0, 0, 0, 1, 32'h104, 32'h40B5_0533);
    for (int i = 0; i < 3; i++)
      step("stall3", 0, 1, 0, 1, 32'h108, 32'hFFFF_FFFF);
    step("unstall", 0, 0, 0, 1, 32'h108, 32'hFFFF_FFFF);
    step("load10c", 0, 0, 0, 1, 32'h10C, 32'h0031_0093);
    step("flush_stall", 0, 1, 1, 1, 32'h110, 32'h0000_0073);
    step("invalid", 0, 0, 0, 0, 32'h200, 32'hDEAD_BEEF);
    step("load300", 0, 0, 0, 1, 32'h300, 32'h0010_0113);
    step("rst_mid_stall_s", 0, 1, 0, 1, 32'h304, 32'h1111_1111);
    step("rst_mid_stall", 1, 1, 0, 1, 32'h304, 32'h2222_2222);
    step("post_rst_load", 0, 0, 0, 1, 32'h308, 32'h0020_8233);
    for (int i = 0; i < 5; i++)
      step("cnt_stall", 0, 1, 0, 1, 32'h400, 32'h1234_5678);
    step("cnt_flush", 0, 0, 1, 1, 32'h404, 32'h1234_5678);
    step("cnt_rst", 1, 0, 0, 1, 32'h408, 32'h1234_5678);
    for (int i = 0; i < 400; i++) begin
      step("random",
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) != 0,
           $urandom & 32'hFFFF_FFFC,
           $urandom);
    end
    @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
